uart_tx_arbiter: RTL and testbench

//  Round-robin scheduler sharing one uart_byte_tx instance among NUM_REQ byte sources
//  (e.g. rx loopback, status reporter, debug dumper).

---
 rtl/uart_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: arbiter state encodings, byte width, baud codes
//
// Purpose: common types and constants for the UART transmit path.
//   arb_state_e  : uart_tx_arbiter FSM states
//   BYTE_W       : width of one UART data byte
//   baud_set_e   : baud-rate select codes understood by uart_byte_tx/uart_byte_rx
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_e;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_set_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker for uart_tx_arbiter
//
// Purpose: choose one active request, searching from (ptr_i+1) mod NUM_REQ upward
//          with wrap-around. The pointer register lives in the parent.
// Ports:
//   req_i    in   NUM_REQ  request vector
//   ptr_i    in   3        index of the last granted source
//   gnt_o    out  NUM_REQ  one-hot grant (all zero when no request)
//   idx_o    out  3        index of the granted source
//   valid_o  out  1        at least one request is active
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [2:0]         ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [2:0]         idx_o,
  output logic               valid_o
);

  always_comb begin : pick
    int   cand;
    logic found;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    found   = 1'b0;
    cand    = 0;
    // Offsets 1..NUM_REQ visit every source once; the last one is ptr itself,
    // so a lone requester that was just served still wins.
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(ptr_i) + off) % NUM_REQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = 3'(cand);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one uart_byte_tx among byte sources
//
// Purpose: grant one byte per round to NUM_REQ requesters, launch it on uart_byte_tx,
//          wait for Tx_Done under a watchdog, then hold an inter-byte gap.
// Ports:
//   Clk, Rst_n   clock, asynchronous active-low reset
//   req          per-source level request, held until ack
//   req_data     byte of source i at [8*i+7:8*i]
//   ack          one-hot pulse: byte of that source latched
//   data_byte    registered byte to uart_byte_tx
//   send_en      1-cycle start pulse to uart_byte_tx
//   Tx_Done      end-of-frame pulse from uart_byte_tx
//   uart_state   frame-in-progress status from uart_byte_tx
//   grant_id     index of current/last granted source
//   busy         high in every state except IDLE
//   timeout_err  1-cycle pulse when the watchdog expires
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [BYTE_W-1:0]         data_byte,
  output logic                      send_en,
  input  logic                      Tx_Done,
  input  logic                      uart_state,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  arb_state_e          state_q;
  logic [2:0]          ptr_q;
  logic [WD_W-1:0]     wd_cnt_q,  wd_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                arm_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [BYTE_W-1:0]   data_byte_q;
  logic                send_en_q;
  logic [2:0]          grant_id_q;
  logic                busy_q;
  logic                timeout_err_q;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [2:0]          arb_idx;
  logic                arb_valid;
  logic [BYTE_W-1:0]   win_byte;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) win_byte = req_data[BYTE_W*i +: BYTE_W];
    end
  end

  // Saturating increments: neither counter may wrap.
  always_comb begin
    wd_cnt_d  = (wd_cnt_q  == WD_LAST)  ? wd_cnt_q  : wd_cnt_q  + WD_W'(1);
    gap_cnt_d = (gap_cnt_q == GAP_LAST) ? gap_cnt_q : gap_cnt_q + GAP_W'(1);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= 3'(NUM_REQ - 1);
      wd_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      arm_q         <= 1'b0;
      ack_q         <= '0;
      data_byte_q   <= '0;
      send_en_q     <= 1'b0;
      grant_id_q    <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      // arm_q blocks a grant on the first edge after reset release, so send_en
      // stays low during and on the cycle after release.
      arm_q         <= 1'b1;
      send_en_q     <= 1'b0;
      ack_q         <= '0;
      timeout_err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // Winner is registered here so send_en/ack appear in the LOAD cycle.
          if (arm_q && arb_valid && !uart_state) begin
            state_q     <= ST_LOAD;
            data_byte_q <= win_byte;
            send_en_q   <= 1'b1;
            ack_q       <= arb_gnt;
            grant_id_q  <= arb_idx;
            ptr_q       <= arb_idx;
            busy_q      <= 1'b1;
          end
        end
        ST_LOAD: begin
          state_q  <= ST_BUSY;
          wd_cnt_q <= '0;
        end
        ST_BUSY: begin
          if (Tx_Done) begin
            // Tx_Done has priority over a simultaneous expiry.
            state_q   <= ST_GAP;
            gap_cnt_q <= '0;
          end else if (wd_cnt_d == WD_LAST) begin
            // Expiry is decided one cycle early so the registered error pulse
            // lands TIMEOUT_CYC cycles after the LOAD cycle.
            state_q       <= ST_GAP;
            gap_cnt_q     <= '0;
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= 1'b1;
          end else begin
            wd_cnt_q <= wd_cnt_d;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack         = ack_q;
  assign data_byte   = data_byte_q;
  assign send_en     = send_en_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int GAP   = 16;
  localparam int TMO   = 100;
  localparam int TXLAT = 20;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0] ack;
  logic [7:0]      data_byte;
  logic            send_en;
  logic            Tx_Done;
  logic            uart_state;
  logic [2:0]      grant_id;
  logic            busy;
  logic            timeout_err;

  uart_tx_arbiter #(
    .NUM_REQ     (NREQ),
    .GAP_CYC     (GAP),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .Clk         (clk),
    .Rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .data_byte   (data_byte),
    .send_en     (send_en),
    .Tx_Done     (Tx_Done),
    .uart_state  (uart_state),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_sends = 0;
  int n_done = 0;
  int n_tmo = 0;
  int last_send_cyc = 0;
  int done_cyc = 0;
  int tx_delay = TXLAT;
  bit tx_auto = 1;
  bit chk_gap = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int id, input logic [7:0] b);
    exp_t e;
    e.id = 3'(id);
    e.data = b;
    sb_q.push_back(e);
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every send_en must match the next expected grant.
  always @(negedge clk) begin
    if (rst_n && send_en) begin
      n_sends++;
      last_send_cyc = cyc;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_send", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_grant_id", 32'(grant_id), 32'(e.id));
        check("sb_data_byte", 32'(data_byte), 32'(e.data));
        check("sb_ack", 32'(ack), 32'(1 << e.id));
        if (chk_gap) check("gap_after_done", 32'(cyc - done_cyc), 32'(GAP + 2));
      end
    end
    if (rst_n && timeout_err) n_tmo++;
  end

  // uart_byte_tx model: Tx_Done tx_delay cycles after send_en.
  initial begin : tx_model
    bit pending;
    int tcnt;
    pending = 0;
    tcnt = 0;
    Tx_Done = 0;
    uart_state = 0;
    forever begin
      @(negedge clk);
      Tx_Done = 0;
      if (!rst_n) begin
        pending = 0;
      end else if (send_en) begin
        pending = tx_auto;
        tcnt = 0;
      end else if (pending) begin
        tcnt++;
        if (tcnt == tx_delay) begin
          Tx_Done = 1;
          pending = 0;
          done_cyc = cyc;
          n_done++;
        end
      end
      uart_state = pending;
    end
  end

  task automatic wait_sends(input int target, input int budget, input string tag);
    int k = 0;
    while (n_sends < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(tag, 32'(n_sends >= target), 32'd1);
    #1;
  endtask

  task automatic wait_idle(input int budget, input string tag, output int at);
    int k = 0;
    @(negedge clk);
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(busy), 32'd0);
    at = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tmo(input int budget, output int at);
    int k = 0;
    @(negedge clk);
    while (!timeout_err && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("t4_tmo_seen", 32'(timeout_err), 32'd1);
    at = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    req = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : global_guard
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int t0, idle_at, tmo_at, base_s, base_d, base_t, rel;
    rst_n = 0;
    req = '0;
    req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({ack, data_byte, send_en, grant_id, busy, timeout_err}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1;
    repeat (3) @(posedge clk);
    #1;

    // 1: single source
    req_data[7:0] = 8'h55;
    push(0, 8'h55);
    req = 4'b0001;
    t0 = cyc;
    wait_sends(1, 10, "t1_send_seen");
    check("t1_latency", 32'(last_send_cyc), 32'(t0 + 1));
    req = '0;
    wait_idle(200, "t1_idle", idle_at);
    check("t1_gap_to_idle", 32'(idle_at - done_cyc), 32'(GAP + 1));
    check("t1_byte_hold", 32'(data_byte), 32'h55);

    // 2: all four held, round robin from source 0
    apply_reset();
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    push(0, 8'hA0); push(1, 8'hA1); push(2, 8'hA2); push(3, 8'hA3); push(0, 8'hA0);
    base_s = n_sends;
    base_d = n_done;
    req = 4'b1111;
    wait_sends(base_s + 1, 10, "t2_first_send");
    chk_gap = 1;
    wait_sends(base_s + 5, 400, "t2_five_sends");
    chk_gap = 0;
    req = '0;
    wait_idle(200, "t2_idle", idle_at);
    check("t2_one_send_per_done", 32'(n_sends - base_s), 32'(n_done - base_d));

    // 3: fairness, ptr is 0 after test 2
    req_data = {8'h33, 8'h22, 8'h11, 8'h00};
    base_s = n_sends;
    push(2, 8'h22);
    req = 4'b0100;
    wait_sends(base_s + 1, 10, "t3_send_src2");
    push(1, 8'h11);
    push(2, 8'h22);
    req = 4'b0110;
    wait_sends(base_s + 2, 200, "t3_send_src1");
    req = 4'b0100;
    wait_sends(base_s + 3, 200, "t3_send_src2_again");
    req = '0;
    wait_idle(200, "t3_idle", idle_at);

    // 4: watchdog expiry
    tx_auto = 0;
    base_s = n_sends;
    base_t = n_tmo;
    req_data[7:0] = 8'h5A;
    push(0, 8'h5A);
    req = 4'b0001;
    wait_sends(base_s + 1, 10, "t4_send");
    req = '0;
    t0 = last_send_cyc;
    wait_tmo(TMO + 20, tmo_at);
    check("t4_tmo_latency", 32'(tmo_at - t0), 32'(TMO));
    wait_idle(200, "t4_idle", idle_at);
    check("t4_tmo_count", 32'(n_tmo - base_t), 32'd1);
    check("t4_gap_after_tmo", 32'(idle_at - tmo_at), 32'(GAP));
    tx_auto = 1;
    req_data[15:8] = 8'h3C;
    push(1, 8'h3C);
    req = 4'b0010;
    wait_sends(base_s + 2, 10, "t4_next_served");
    req = '0;
    wait_idle(200, "t4_idle2", idle_at);

    // 5: Tx_Done coincides with watchdog expiry
    tx_delay = TMO - 1;
    base_s = n_sends;
    base_t = n_tmo;
    req_data[31:24] = 8'hC3;
    push(3, 8'hC3);
    req = 4'b1000;
    wait_sends(base_s + 1, 10, "t5_send");
    req = '0;
    t0 = last_send_cyc;
    wait_idle(400, "t5_idle", idle_at);
    check("t5_done_at_expiry", 32'(done_cyc - t0), 32'(TMO - 1));
    check("t5_no_tmo", 32'(n_tmo - base_t), 32'd0);
    check("t5_normal_gap", 32'(idle_at - done_cyc), 32'(GAP + 1));
    tx_delay = TXLAT;

    // 6: reset mid-BUSY
    base_s = n_sends;
    req_data[23:16] = 8'h77;
    push(2, 8'h77);
    req = 4'b0100;
    wait_sends(base_s + 1, 10, "t6_send");
    req = '0;
    repeat (5) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("t6_reset_outputs", 32'({ack, data_byte, send_en, grant_id, busy, timeout_err}), 32'd0);
    req_data = {8'h93, 8'h92, 8'h91, 8'h90};
    req = 4'b1111;
    push(0, 8'h90);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    rel = cyc;
    wait_sends(base_s + 2, 10, "t6_send_after_reset");
    check("t6_first_send_cycle", 32'(last_send_cyc - rel), 32'd2);
    req = '0;
    wait_idle(200, "t6_idle", idle_at);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
